// File: rtl/fft8_pkg.sv
// rtl/fft8_pkg.sv - shared widths and sample types for the 8-point FFT datapath
//
// Purpose: common constants and types used by the input buffer, FFT core and
//          result-capture stages.
// Contents: DATA_W (sample width), N_PTS (frame length), IDX_W (sample index
//           width), sample_t (signed sample), idx_t (sample index).
package fft8_pkg;

    localparam int DATA_W = 16;
    localparam int N_PTS  = 8;
    localparam int IDX_W  = 3;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic [IDX_W-1:0]         idx_t;

endpackage

// File: rtl/fft8_input_buffer_if.sv
// rtl/fft8_input_buffer_if.sv - sample stream and frame handshake bundle of the FFT input buffer
//
// Purpose: groups the sample-side and frame-side handshake signals.
// Signals:
//   in_data/in_valid/in_sof/in_ready  sample stream, one sample per handshake
//   x0..x7                            parallel frame samples, sample k on xk
//   frame_valid/frame_ready           frame handshake
//   sof_err                           one-cycle pulse when a partial frame is dropped
// Modports:
//   slave   buffer side (consumes samples, produces frames)
//   master  environment side (produces samples, consumes frames)
interface fft8_input_buffer_if;
    import fft8_pkg::*;

    sample_t in_data;
    logic    in_valid;
    logic    in_sof;
    logic    in_ready;
    sample_t x0, x1, x2, x3, x4, x5, x6, x7;
    logic    frame_valid;
    logic    frame_ready;
    logic    sof_err;

    modport slave (
        input  in_data, in_valid, in_sof, frame_ready,
        output in_ready, x0, x1, x2, x3, x4, x5, x6, x7, frame_valid, sof_err
    );

    modport master (
        output in_data, in_valid, in_sof, frame_ready,
        input  in_ready, x0, x1, x2, x3, x4, x5, x6, x7, frame_valid, sof_err
    );

endinterface

// File: rtl/fft8_frame_bank.sv
// rtl/fft8_frame_bank.sv - one 8-sample register bank with indexed write and parallel read
//
// Purpose: holds one frame of samples.
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears all entries)
//   clr        synchronous clear of all entries
//   we         write enable
//   wr_idx     entry written when we is high
//   wr_data    sample written
//   rd_data    all entries, entry k on rd_data[k]
module fft8_frame_bank
    import fft8_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    clr,
    input  logic    we,
    input  idx_t    wr_idx,
    input  sample_t wr_data,
    output sample_t rd_data [N_PTS]
);

    sample_t mem [N_PTS];

    // clr and we may be asserted together: the clear applies to every entry
    // and the write then lands on top of it, so a restarted frame begins clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PTS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (clr) begin
                for (int i = 0; i < N_PTS; i++) begin
                    mem[i] <= '0;
                end
            end
            if (we) begin
                mem[wr_idx] <= wr_data;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_PTS; i++) begin
            rd_data[i] = mem[i];
        end
    end

endmodule

// File: rtl/fft8_input_buffer.sv
// rtl/fft8_input_buffer.sv - streaming-to-parallel ping-pong frame buffer feeding the 8-point FFT
//
// Purpose: collects 8 serial samples per frame into alternating banks and
//          presents each complete frame in parallel on x0..x7.
// Ports:
//   clk     clock, rising edge
//   rst     asynchronous active-high reset; drops all partial and full frames
//   bus     slave side of fft8_input_buffer_if (sample stream in, frame out)
module fft8_input_buffer
    import fft8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fft8_input_buffer_if.slave   bus
);

    localparam idx_t LAST_IDX = idx_t'(N_PTS - 1);

    logic [1:0] bank_full;
    logic       wr_bank;
    logic       rd_bank;
    idx_t       wr_idx;
    logic       sof_err_q;

    logic       in_ready_int;
    logic       accept;
    logic       restart;
    logic       frame_done;
    logic       frame_fire;
    idx_t       bank_widx;

    sample_t    bank0_q [N_PTS];
    sample_t    bank1_q [N_PTS];
    sample_t    rd_q    [N_PTS];

    // Ready comes from registered state only, so the source may wait on it.
    assign in_ready_int = !bank_full[wr_bank];
    assign accept       = bus.in_valid && in_ready_int;
    // A start-of-frame in the middle of a frame drops what was collected and
    // restarts the current bank at index 0.
    assign restart      = accept && bus.in_sof && (wr_idx != '0);
    assign frame_done   = accept && !restart && (wr_idx == LAST_IDX);
    assign frame_fire   = bank_full[rd_bank] && bus.frame_ready;
    assign bank_widx    = restart ? idx_t'(0) : wr_idx;

    fft8_frame_bank u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .clr     (restart && !wr_bank),
        .we      (accept && !wr_bank),
        .wr_idx  (bank_widx),
        .wr_data (bus.in_data),
        .rd_data (bank0_q)
    );

    fft8_frame_bank u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .clr     (restart && wr_bank),
        .we      (accept && wr_bank),
        .wr_idx  (bank_widx),
        .wr_data (bus.in_data),
        .rd_data (bank1_q)
    );

    // The write bank is never full when accepting and the read bank is always
    // full when firing, so the two updates of bank_full touch different bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            sof_err_q <= 1'b0;
        end else begin
            sof_err_q <= restart;
            if (accept) begin
                if (restart) begin
                    wr_idx <= idx_t'(1);
                end else if (frame_done) begin
                    wr_idx  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_idx <= wr_idx + idx_t'(1);
                end
            end
            if (frame_done) begin
                bank_full[wr_bank] <= 1'b1;
            end
            if (frame_fire) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_PTS; i++) begin
            rd_q[i] = rd_bank ? bank1_q[i] : bank0_q[i];
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.frame_valid = bank_full[rd_bank];
    assign bus.sof_err     = sof_err_q;
    assign bus.x0          = rd_q[0];
    assign bus.x1          = rd_q[1];
    assign bus.x2          = rd_q[2];
    assign bus.x3          = rd_q[3];
    assign bus.x4          = rd_q[4];
    assign bus.x5          = rd_q[5];
    assign bus.x6          = rd_q[6];
    assign bus.x7          = rd_q[7];

endmodule

// File: tb/tb_fft8_input_buffer.sv
// tb/tb_fft8_input_buffer.sv - directed self-checking bench for fft8_input_buffer
module tb_fft8_input_buffer;
    import fft8_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fft8_input_buffer_if bus ();

    fft8_input_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] xs [8];
    always_comb begin
        xs[0] = bus.x0; xs[1] = bus.x1; xs[2] = bus.x2; xs[3] = bus.x3;
        xs[4] = bus.x4; xs[5] = bus.x5; xs[6] = bus.x6; xs[7] = bus.x7;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_data = '0; bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.frame_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%b exp=0", bus.frame_valid); end
        total++; if (bus.sof_err !== 1'b0) begin bad++; $display("FAIL reset_sof_err got=%b exp=0", bus.sof_err); end
        for (int i = 0; i < 8; i++) begin
            total++; if (xs[i] !== 16'h0000) begin bad++; $display("FAIL reset_x%0d got=%h exp=0000", i, xs[i]); end
        end
    endtask

    task automatic test_basic_frame();
        bus.frame_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_data = sample_t'(k + 1); bus.in_valid = 1'b1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready k=%0d got=%b exp=1", k, bus.in_ready); end
            total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid k=%0d got=%b exp=0", k, bus.frame_valid); end
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL basic_frame_valid got=%b exp=1", bus.frame_valid); end
        for (int i = 0; i < 8; i++) begin
            total++; if (xs[i] !== 16'(i + 1)) begin bad++; $display("FAIL basic_x%0d got=%h exp=%h", i, xs[i], 16'(i + 1)); end
        end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_end got=%b exp=1", bus.in_ready); end
        tick();
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_one_cycle got=%b exp=0", bus.frame_valid); end
    endtask

    task automatic test_backpressure();
        bus.frame_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            bus.in_data = sample_t'(16'h0100 + c); bus.in_valid = 1'b1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b exp=1", c, bus.in_ready); end
            tick();
        end
        bus.in_data = sample_t'(16'h0110);
        for (int w = 0; w < 3; w++) begin
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready w=%0d got=%b exp=0", w, bus.in_ready); end
            total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL bp_frame_valid w=%0d got=%b exp=1", w, bus.frame_valid); end
            for (int i = 0; i < 8; i++) begin
                total++; if (xs[i] !== 16'(16'h0100 + i)) begin bad++; $display("FAIL bp_stable_x%0d w=%0d got=%h exp=%h", i, w, xs[i], 16'(16'h0100 + i)); end
            end
            tick();
        end
        bus.frame_ready = 1'b1;
        tick();
        bus.frame_ready = 1'b0;
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL bp_swap_valid got=%b exp=1", bus.frame_valid); end
        total++; if (xs[0] !== 16'h0108) begin bad++; $display("FAIL bp_swap_x0 got=%h exp=0108", xs[0]); end
        total++; if (xs[7] !== 16'h010F) begin bad++; $display("FAIL bp_swap_x7 got=%h exp=010f", xs[7]); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return got=%b exp=1", bus.in_ready); end
        for (int c = 16; c < 24; c++) begin
            bus.in_data = sample_t'(16'h0100 + c); bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_refull_in_ready got=%b exp=0", bus.in_ready); end
        bus.frame_ready = 1'b1;
        tick();
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL bp_third_valid got=%b exp=1", bus.frame_valid); end
        total++; if (xs[0] !== 16'h0110) begin bad++; $display("FAIL bp_third_x0 got=%h exp=0110", xs[0]); end
        total++; if (xs[7] !== 16'h0117) begin bad++; $display("FAIL bp_third_x7 got=%h exp=0117", xs[7]); end
        tick();
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", bus.frame_valid); end
    endtask

    task automatic test_sof_restart();
        logic [15:0] pre [3];
        int pulses;
        pre[0] = 16'h0011; pre[1] = 16'h0022; pre[2] = 16'h0033;
        pulses = 0;
        bus.frame_ready = 1'b0; bus.in_sof = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = sample_t'(pre[k]); bus.in_valid = 1'b1;
            tick();
            if (bus.sof_err === 1'b1) pulses++;
        end
        bus.in_data = sample_t'(16'hAAAA); bus.in_sof = 1'b1;
        tick();
        bus.in_sof = 1'b0;
        total++; if (bus.sof_err !== 1'b1) begin bad++; $display("FAIL sof_err_pulse got=%b exp=1", bus.sof_err); end
        if (bus.sof_err === 1'b1) pulses++;
        for (int k = 1; k < 8; k++) begin
            bus.in_data = sample_t'(k);
            tick();
            if (bus.sof_err === 1'b1) pulses++;
        end
        bus.in_valid = 1'b0;
        total++; if (pulses !== 1) begin bad++; $display("FAIL sof_err_count got=%0d exp=1", pulses); end
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL sof_frame_valid got=%b exp=1", bus.frame_valid); end
        total++; if (xs[0] !== 16'hAAAA) begin bad++; $display("FAIL sof_x0 got=%h exp=aaaa", xs[0]); end
        for (int i = 1; i < 8; i++) begin
            total++; if (xs[i] !== 16'(i)) begin bad++; $display("FAIL sof_x%0d got=%h exp=%h", i, xs[i], 16'(i)); end
        end
        bus.frame_ready = 1'b1;
        tick();
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL sof_drained got=%b exp=0", bus.frame_valid); end
    endtask

    task automatic test_full_scale();
        bus.frame_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.in_data = (k % 2 == 0) ? sample_t'(16'h8000) : sample_t'(16'h7FFF);
            bus.in_valid = 1'b1;
            bus.in_sof = (k == 0);
            tick();
            total++; if (bus.sof_err !== 1'b0) begin bad++; $display("FAIL fs_sof_err k=%0d got=%b exp=0", k, bus.sof_err); end
        end
        bus.in_valid = 1'b0; bus.in_sof = 1'b0;
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL fs_frame_valid got=%b exp=1", bus.frame_valid); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (xs[i] !== ((i % 2 == 0) ? 16'h8000 : 16'h7FFF)) begin
                bad++; $display("FAIL fs_x%0d got=%h exp=%h", i, xs[i], (i % 2 == 0) ? 16'h8000 : 16'h7FFF);
            end
        end
        bus.frame_ready = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.frame_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            bus.in_data = sample_t'(16'h0300 + c); bus.in_valid = 1'b1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, bus.in_ready); end
            if (c == 8) begin
                total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_first_valid got=%b exp=1", bus.frame_valid); end
                total++; if (xs[0] !== 16'h0300) begin bad++; $display("FAIL b2b_first_x0 got=%h exp=0300", xs[0]); end
                total++; if (xs[7] !== 16'h0307) begin bad++; $display("FAIL b2b_first_x7 got=%h exp=0307", xs[7]); end
            end
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_second_valid got=%b exp=1", bus.frame_valid); end
        total++; if (xs[0] !== 16'h0308) begin bad++; $display("FAIL b2b_second_x0 got=%h exp=0308", xs[0]); end
        total++; if (xs[7] !== 16'h030F) begin bad++; $display("FAIL b2b_second_x7 got=%h exp=030f", xs[7]); end
        tick();
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", bus.frame_valid); end
    endtask

    task automatic test_mid_frame_reset();
        bus.frame_ready = 1'b0;
        for (int c = 0; c < 13; c++) begin
            bus.in_data = sample_t'(16'h0400 + c); bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL rst_pending_valid got=%b exp=1", bus.frame_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (bus.frame_valid !== 1'b0) begin bad++; $display("FAIL rst_frame_valid got=%b exp=0", bus.frame_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.sof_err !== 1'b0) begin bad++; $display("FAIL rst_sof_err got=%b exp=0", bus.sof_err); end
        for (int i = 0; i < 8; i++) begin
            total++; if (xs[i] !== 16'h0000) begin bad++; $display("FAIL rst_x%0d got=%h exp=0000", i, xs[i]); end
        end
        for (int k = 0; k < 8; k++) begin
            bus.in_data = sample_t'(16'h0051 + k); bus.in_valid = 1'b1;
            bus.in_sof = (k == 0);
            tick();
        end
        bus.in_valid = 1'b0; bus.in_sof = 1'b0;
        total++; if (bus.frame_valid !== 1'b1) begin bad++; $display("FAIL rst_fresh_valid got=%b exp=1", bus.frame_valid); end
        for (int i = 0; i < 8; i++) begin
            total++; if (xs[i] !== 16'(16'h0051 + i)) begin bad++; $display("FAIL rst_fresh_x%0d got=%h exp=%h", i, xs[i], 16'(16'h0051 + i)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_sof_restart();
        test_full_scale();
        test_back_to_back();
        test_mid_frame_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
